// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity constants and majority vote for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - tick divider and per-bit sample counter with mid-bit/bit-end strobes
module uart_rx_sampler #(
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic samp_early,
    output logic mid_bit,
    output logic bit_end
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] samp_cnt;
    logic          tick;

    assign tick = run && (tick_cnt == TICK_LAST);

    // Both counters sit at zero while idle so a start edge always begins at tick 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (!run) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            end
        end
    end

    // The first two votes are captured early; the third is taken live with mid_bit.
    assign samp_early = tick && ((samp_cnt == SAMP_A) || (samp_cnt == SAMP_B));
    assign mid_bit    = tick && (samp_cnt == SAMP_C);
    assign bit_end    = tick && (samp_cnt == SAMP_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/framing checks and held output word
module uart_rx_core #(
    parameter int DATA_W        = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 1,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    import uart_pkg::*;

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    rx_state_t         state, state_nxt;
    logic              sync1, rx_s, rx_d;
    logic              start_edge;
    logic              samp_early, mid_bit, bit_end;
    logic [1:0]        samp_sh;
    logic              bit_val;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              last_stop;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, par_err_r, frm_err_r;
    logic              deliver;
    logic              word_pe, word_fe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;
    assign busy       = (state != ST_IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE    (OVERSAMPLE),
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .run        (busy),
        .samp_early (samp_early),
        .mid_bit    (mid_bit),
        .bit_end    (bit_end)
    );

    assign bit_val   = maj3(samp_sh[1], samp_sh[0], rx_s);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        case (state)
            ST_IDLE:   if (start_edge) state_nxt = ST_START;
            ST_START: begin
                if (mid_bit && bit_val) state_nxt = ST_IDLE;
                else if (bit_end)       state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == BIT_LAST)) begin
                    state_nxt = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP: begin
                // Hand off mid-bit so a following start edge is never missed.
                if (mid_bit && last_stop) begin
                    state_nxt = ST_IDLE;
                    deliver   = 1'b1;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_sh   <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            if (samp_early) samp_sh <= {samp_sh[0], rx_s};
            case (state)
                ST_IDLE: begin
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                    par_acc   <= 1'b0;
                    frm_err_r <= 1'b0;
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        shreg   <= {bit_val, shreg[DATA_W-1:1]};
                        par_acc <= par_acc ^ bit_val;
                    end
                    if (bit_end) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
                ST_PARITY: begin
                    if (mid_bit) par_err_r <= (par_acc ^ bit_val) != (PARITY_MODE == PARITY_ODD);
                end
                ST_STOP: begin
                    if (mid_bit && !bit_val) frm_err_r <= 1'b1;
                    if (bit_end)             stop_cnt  <= stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Delivery coincides with the last stop vote, so fold that vote in directly.
    assign word_fe = frm_err_r | ~bit_val;
    assign word_pe = (PARITY_MODE != PARITY_NONE) && par_err_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= deliver && data_valid && !data_ready;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                parity_err <= word_pe;
                frame_err  <= word_fe;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized scoreboard bench over three receiver configurations
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx         [3];
    logic       data_ready [3];
    logic [7:0] data_out   [3];
    logic       data_valid [3];
    logic       parity_err [3];
    logic       frame_err  [3];
    logic       overrun    [3];
    logic       busy       [3];

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16), .CLKS_PER_TICK(1), .PARITY_MODE(1), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .rx_in(rx[0]), .data_out(data_out[0]), .data_valid(data_valid[0]),
        .data_ready(data_ready[0]), .parity_err(parity_err[0]), .frame_err(frame_err[0]),
        .overrun(overrun[0]), .busy(busy[0]));

    uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16), .CLKS_PER_TICK(1), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .rx_in(rx[1]), .data_out(data_out[1]), .data_valid(data_valid[1]),
        .data_ready(data_ready[1]), .parity_err(parity_err[1]), .frame_err(frame_err[1]),
        .overrun(overrun[1]), .busy(busy[1]));

    uart_rx_core #(.DATA_W(8), .OVERSAMPLE(8), .CLKS_PER_TICK(3), .PARITY_MODE(0), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .rx_in(rx[2]), .data_out(data_out[2]), .data_valid(data_valid[2]),
        .data_ready(data_ready[2]), .parity_err(parity_err[2]), .frame_err(frame_err[2]),
        .overrun(overrun[2]), .busy(busy[2]));

    // Scoreboard: the stimulus side owns push_cnt/expw/exp_ovr, the monitor owns pop_cnt/last_got/ovr_cnt.
    int         push_cnt [3] = '{0, 0, 0};
    int         pop_cnt  [3] = '{0, 0, 0};
    int         exp_ovr  [3] = '{0, 0, 0};
    int         ovr_cnt  [3] = '{0, 0, 0};
    logic [9:0] expw     [3];
    logic [9:0] last_got [3];
    int         err_t = 0, chk_t = 0;
    int         err_c = 0, chk_c = 0;

    function automatic int pm_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 0;
    endfunction

    function automatic int nstop_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int bitp_of(input int d);
        return (d == 2) ? 24 : 16;
    endfunction

    // Expected {frame_err, parity_err, data} from the bits actually put on the line.
    function automatic logic [9:0] model_word(input int d, input logic [7:0] w, input logic pbit,
                                              input logic [1:0] stops);
        logic pe, fe;
        pe = (pm_of(d) == 0) ? 1'b0 : ((^w ^ pbit) != (pm_of(d) == 2));
        fe = (stops[0] == 1'b0) || ((nstop_of(d) == 2) && (stops[1] == 1'b0));
        return {fe, pe, w};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_t++;
        if (got !== exp) begin
            err_t++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input int d, input logic v, input int gl_at, input int gl_len);
        for (int c = 0; c < bitp_of(d); c++) begin
            rx[d] = (c >= gl_at && c < gl_at + gl_len) ? ~v : v;
            step(1);
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] w, input logic pflip,
                              input logic [1:0] stops, input int gbit);
        logic pbit;
        pbit = ^w ^ (pm_of(d) == 2) ^ pflip;
        drive_bit(d, 1'b0, -1, 0);
        for (int i = 0; i < 8; i++) drive_bit(d, w[i], (i == gbit) ? bitp_of(d) / 2 : -1, 1);
        if (pm_of(d) != 0) drive_bit(d, pbit, -1, 0);
        for (int s = 0; s < nstop_of(d); s++) begin
            if (s == nstop_of(d) - 1) begin
                if (push_cnt[d] != pop_cnt[d]) exp_ovr[d]++;
                else begin
                    expw[d] = model_word(d, w, pbit, stops);
                    push_cnt[d]++;
                end
            end
            drive_bit(d, stops[s], -1, 0);
        end
        rx[d] = 1'b1;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (push_cnt[d] != pop_cnt[d] && t < 3000) begin
            step(1);
            t++;
        end
        check($sformatf("drain_dut%0d", d), 32'(pop_cnt[d]), 32'(push_cnt[d]));
    endtask

    initial begin : monitor
        logic [9:0] got;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (overrun[d] === 1'b1) ovr_cnt[d]++;
                if (data_valid[d] === 1'b1) begin
                    got = {frame_err[d], parity_err[d], data_out[d]};
                    chk_c++;
                    if (push_cnt[d] == pop_cnt[d]) begin
                        err_c++;
                        $display("FAIL dut%0d unexpected_valid got=%h expected=none", d, got);
                    end else begin
                        if (got !== expw[d]) begin
                            err_c++;
                            $display("FAIL dut%0d word got=%h expected=%h", d, got, expw[d]);
                        end
                        if (data_ready[d]) begin
                            last_got[d] = got;
                            pop_cnt[d]++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stimulus
        int         base, d, gap;
        logic [7:0] w;
        logic       pflip;
        logic [1:0] stops;

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx[i]         = 1'b1;
            data_ready[i] = 1'b1;
            expw[i]       = '0;
        end
        step(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_outputs_dut%0d", i),
                  32'({data_out[i], data_valid[i], parity_err[i], frame_err[i], overrun[i], busy[i]}), 32'd0);
        end
        reset = 1'b1;
        step(10);

        send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
        drain(0);
        check("even_parity_a5", 32'(last_got[0]), 32'h0A5);

        send_frame(1, 8'h3C, 1'b1, 2'b11, -1);
        drain(1);
        check("odd_parity_err_3c", 32'(last_got[1]), 32'h13C);

        send_frame(0, 8'h7E, 1'b0, 2'b10, -1);
        step(4);
        drain(0);
        check("stop_low_7e", 32'(last_got[0]), 32'h27E);

        send_frame(1, 8'h7E, 1'b0, 2'b01, -1);
        step(4);
        drain(1);
        check("second_stop_low_7e", 32'(last_got[1]), 32'h27E);

        rx[0] = 1'b0;
        step(6);
        rx[0] = 1'b1;
        check("glitch_busy_high", 32'(busy[0]), 32'd1);
        step(40);
        check("glitch_busy_low", 32'(busy[0]), 32'd0);

        send_frame(0, 8'h00, 1'b0, 2'b11, 3);
        drain(0);
        check("midbit_glitch_00", 32'(last_got[0]), 32'h000);

        data_ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, -1);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1);
        step(30);
        check("overrun_pulses", 32'(ovr_cnt[0]), 32'd1);
        check("held_word", 32'({data_valid[0], data_out[0]}), 32'h111);
        data_ready[0] = 1'b1;
        drain(0);
        check("held_word_accepted", 32'(last_got[0]), 32'h011);

        base = pop_cnt[0];
        send_frame(0, 8'h81, 1'b0, 2'b11, -1);
        send_frame(0, 8'h42, 1'b0, 2'b11, -1);
        drain(0);
        check("back_to_back_count", 32'(pop_cnt[0] - base), 32'd2);
        check("back_to_back_word", 32'(last_got[0]), 32'h042);

        drive_bit(0, 1'b0, -1, 0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, -1, 0);
        check("busy_before_reset", 32'(busy[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("reset_midframe_outputs",
              32'({data_out[0], data_valid[0], parity_err[0], frame_err[0], overrun[0], busy[0]}), 32'd0);
        step(5);
        reset = 1'b1;
        step(40);
        check("idle_after_reset", 32'(busy[0]), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 2'b11, -1);
        drain(0);
        check("after_reset_5a", 32'(last_got[0]), 32'h05A);

        for (int n = 0; n < 36; n++) begin
            d     = int'($urandom_range(0, 2));
            w     = 8'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            stops = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
            gap   = int'($urandom_range(0, 12));
            if (stops[nstop_of(d) - 1] == 1'b0) gap = gap + 4;
            send_frame(d, w, pflip, stops, -1);
            step(gap);
        end
        for (int i = 0; i < 3; i++) begin
            drain(i);
            check($sformatf("overrun_total_dut%0d", i), 32'(ovr_cnt[i]), 32'(exp_ovr[i]));
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", err_t + err_c, chk_t + chk_c);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >=4).
REQ-003 SHALL have parameter CLKS_PER_TICK, default 1, clk cycles per sample tick (>=1).
REQ-004 SHALL have parameter PARITY_MODE, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-006 SHALL have port clk, input, 1, system clock; all state on posedge.
REQ-007 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port data_out, output, DATA_W, received word, LSB received first.
REQ-010 SHALL have port data_valid, output, 1, data_out/status valid.
REQ-011 SHALL have port data_ready, input, 1, consumer accepts word when data_valid & data_ready.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch for held word; 0 when PARITY_MODE=0.
REQ-013 SHALL have port frame_err, output, 1, a stop bit sampled low for held word.
REQ-014 SHALL have port overrun, output, 1, one-clk pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-016 rx_in SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-017 Tick generator SHALL pulse once every CLKS_PER_TICK clks; counter is held at 0 in IDLE and restarts on start-edge detection.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-019 IDLE->START SHALL occur on a synchronised high-to-low transition; the sample-tick counter is cleared.
REQ-020 Each bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-021 START: majority = 1 SHALL return to IDLE (glitch reject) without any output change; majority = 0 SHALL enter DATA at bit end.
REQ-022 DATA SHALL shift in DATA_W bits LSB-first; the bit counter wraps to 0 and exits after bit DATA_W-1.
REQ-023 PARITY: error = XOR(data bits, parity bit) != (PARITY_MODE==2).
REQ-024 STOP SHALL sample STOP_BITS bits; any majority-0 stop bit sets frame_err for that word.
REQ-025 Word delivery: at the last stop-bit sample (mid-bit, not bit end), IDLE SHALL be re-entered and the word plus its flags SHALL be loaded into the output register; data_valid SHALL rise the next clk.
REQ-026 Errored words SHALL still be delivered, with flags set.
REQ-027 data_out/flags SHALL be stable while data_valid=1 & data_ready=0; handshake clears data_valid the cycle after acceptance.
REQ-028 Delivery when data_valid=1 and no acceptance that cycle: new word discarded, held word kept, overrun pulses 1 clk.
REQ-029 Simultaneous acceptance and delivery in the same clk: new word loaded, data_valid stays 1, no overrun.
REQ-030 A new start edge SHALL be accepted in the cycle following the return to IDLE, regardless of data_valid.

Reset
REQ-031 Reset low SHALL asynchronously force: FSM IDLE, all counters 0, synchroniser flops 1, data_out 0, data_valid/parity_err/frame_err/overrun/busy 0.
REQ-032 A frame in progress at reset SHALL be abandoned; after release the block waits for a fresh falling edge.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum, the PARITY_NONE/EVEN/ODD constants, and the majority-of-3 function.
REQ-034 Tick/sample counting SHALL be a sub-module uart_rx_sampler (tick divider plus sample counter, emitting mid-bit and bit-end strobes).
REQ-035 The implementation SHALL contain no tristate outputs.

Verification (DATA_W=8, OVERSAMPLE=16, CLKS_PER_TICK=1 unless stated)
REQ-036 Frame 0xA5, PARITY_MODE=1, correct parity, with data_ready=1 -> data_out=0xA5 and data_valid for 1 clk, both error flags 0.
REQ-037 PARITY_MODE=2 with a wrong parity bit on 0x3C -> data_out=0x3C, parity_err=1.
REQ-038 Stop bit low on 0x7E -> frame_err=1; second stop bit low with STOP_BITS=2 -> frame_err=1.
REQ-039 6-tick low glitch on an idle line -> no data_valid, busy returns to 0; 1-tick glitch at centre of bit 3 of 0x00 -> data_out=0x00.
REQ-040 data_ready=0, two frames 0x11 then 0x22 -> data_out holds 0x11, overrun pulses once; back-to-back frames with data_ready=1 -> both delivered.
REQ-041 Reset asserted mid-DATA of 0xFF -> outputs zero immediately; next full frame 0x5A received correctly.
